// File: rtl/v_sram_pkg.sv
// Shared sizing and FSM state type for the V SRAM writer.
package v_sram_pkg;

  localparam int unsigned N_BANKS = 4;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 48;
  localparam int unsigned CNT_W   = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/v_sram_writer_if.sv
// Burst request / source-word handshake between a producer and the V SRAM writer.
interface v_sram_writer_if #(
  parameter int unsigned ADDR_W = v_sram_pkg::ADDR_W,
  parameter int unsigned DATA_W = v_sram_pkg::DATA_W,
  parameter int unsigned CNT_W  = v_sram_pkg::CNT_W
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, word_count, in_valid, in_data,
    input  in_ready, busy, done
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_data,
    output in_ready, busy, done
  );

endinterface

// File: rtl/v_wr_addr_gen.sv
// Beat counter, bank select and row-address generator for the V SRAM writer.
module v_wr_addr_gen #(
  parameter  int unsigned N_BANKS = v_sram_pkg::N_BANKS,
  parameter  int unsigned ADDR_W  = v_sram_pkg::ADDR_W,
  parameter  int unsigned CNT_W   = v_sram_pkg::CNT_W,
  localparam int unsigned BANK_W  = $clog2(N_BANKS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              advance,
  output logic [BANK_W-1:0] bank_c,
  output logic [ADDR_W-1:0] row_c,
  output logic              last_c,
  output logic              wrap_c
);

  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [ADDR_W-1:0] row_q,  row_d;
  logic              bank_last_c;

  assign bank_c      = beat_q[BANK_W-1:0];
  assign bank_last_c = (bank_c == BANK_W'(N_BANKS - 1));
  assign row_c       = row_q;
  assign last_c      = (beat_q == cnt_q - CNT_W'(1));
  // Row steps from all-ones to zero while beats remain in the burst.
  assign wrap_c      = advance && bank_last_c && (&row_q) && !last_c;

  always_comb begin
    beat_d = beat_q;
    cnt_d  = cnt_q;
    row_d  = row_q;
    if (load) begin
      beat_d = '0;
      cnt_d  = word_count;
      row_d  = base_addr;
    end else if (advance) begin
      beat_d = beat_q + CNT_W'(1);
      if (bank_last_c) row_d = row_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
      cnt_q  <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/v_sram_writer.sv
// Streams a burst of source words round-robin into four V SRAM banks.
// Optional sticky err output enabled by defining V_WR_ERR_EN.
module v_sram_writer
  import v_sram_pkg::*;
#(
  parameter int unsigned N_BANKS = v_sram_pkg::N_BANKS,
  parameter int unsigned ADDR_W  = v_sram_pkg::ADDR_W,
  parameter int unsigned DATA_W  = v_sram_pkg::DATA_W,
  parameter int unsigned CNT_W   = v_sram_pkg::CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  v_sram_writer_if.slave    src,
`ifdef V_WR_ERR_EN
  output logic              err,
`endif
  output logic              WE_1,
  output logic              WE_2,
  output logic              WE_3,
  output logic              WE_4,
  output logic [ADDR_W-1:0] sram1_WriteAddress1,
  output logic [ADDR_W-1:0] sram2_WriteAddress1,
  output logic [ADDR_W-1:0] sram3_WriteAddress1,
  output logic [ADDR_W-1:0] sram4_WriteAddress1,
  output logic [DATA_W-1:0] sram1_WriteBus1,
  output logic [DATA_W-1:0] sram2_WriteBus1,
  output logic [DATA_W-1:0] sram3_WriteBus1,
  output logic [DATA_W-1:0] sram4_WriteBus1
);

  localparam int unsigned BANK_W = $clog2(N_BANKS);

  wr_state_e         state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_BANKS-1:0] we_q, we_d;
  logic [ADDR_W-1:0] addr_q [N_BANKS];
  logic [ADDR_W-1:0] addr_d [N_BANKS];
  logic [DATA_W-1:0] wbus_q [N_BANKS];
  logic [DATA_W-1:0] wbus_d [N_BANKS];

  logic              accept_c, load_c, last_c, wrap_c;
  logic [BANK_W-1:0] bank_c;
  logic [ADDR_W-1:0] row_c;

  assign accept_c = src.in_valid && in_ready_q;
  assign load_c   = (state_q == IDLE) && src.start && (src.word_count != '0);

  v_wr_addr_gen #(
    .N_BANKS (N_BANKS),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) u_addr_gen (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load_c),
    .base_addr  (src.base_addr),
    .word_count (src.word_count),
    .advance    (accept_c),
    .bank_c     (bank_c),
    .row_c      (row_c),
    .last_c     (last_c),
    .wrap_c     (wrap_c)
  );

  // Next state plus next registered outputs; in_ready/busy/done follow the next state.
  always_comb begin
    state_d = state_q;
    we_d    = '0;
    addr_d  = addr_q;
    wbus_d  = wbus_q;
    unique case (state_q)
      IDLE:    if (src.start) state_d = (src.word_count == '0) ? DONE : WRITE;
      WRITE:   if (accept_c && last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept_c) begin
      we_d[bank_c]   = 1'b1;
      addr_d[bank_c] = row_c;
      wbus_d[bank_c] = src.in_data;
    end
    in_ready_d = (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= '0;
      for (int unsigned i = 0; i < N_BANKS; i++) begin
        addr_q[i] <= '0;
        wbus_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wbus_q     <= wbus_d;
    end
  end

`ifdef V_WR_ERR_EN
  logic err_q, err_d;

  // Sticky: start while not idle, or a row address wrapping within a burst.
  always_comb begin
    err_d = err_q | (src.start && (state_q != IDLE)) | wrap_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign src.in_ready = in_ready_q;
  assign src.busy     = busy_q;
  assign src.done     = done_q;

  assign WE_1 = we_q[0];
  assign WE_2 = we_q[1];
  assign WE_3 = we_q[2];
  assign WE_4 = we_q[3];

  assign sram1_WriteAddress1 = addr_q[0];
  assign sram2_WriteAddress1 = addr_q[1];
  assign sram3_WriteAddress1 = addr_q[2];
  assign sram4_WriteAddress1 = addr_q[3];

  assign sram1_WriteBus1 = wbus_q[0];
  assign sram2_WriteBus1 = wbus_q[1];
  assign sram3_WriteBus1 = wbus_q[2];
  assign sram4_WriteBus1 = wbus_q[3];

endmodule
